// File: rtl/pcie_tx_arbiter.sv
// Round-robin arbiter sharing the 64-bit PCIe AXI4-Stream TX interface between the completer
// (port 0) and the requester (port 1), switching only at TLP boundaries, plus turn-off handshake.
module pcie_tx_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             user_clk,
  input  logic             user_reset,
  input  logic [63:0]      rq0_tdata,
  input  logic [7:0]       rq0_tkeep,
  input  logic             rq0_tlast,
  input  logic             rq0_tvalid,
  output logic             rq0_tready,
  input  logic [63:0]      rq1_tdata,
  input  logic [7:0]       rq1_tkeep,
  input  logic             rq1_tlast,
  input  logic             rq1_tvalid,
  output logic             rq1_tready,
  output logic [63:0]      s_axis_tx_tdata,
  output logic [7:0]       s_axis_tx_tkeep,
  output logic             s_axis_tx_tlast,
  output logic             s_axis_tx_tvalid,
  input  logic             s_axis_tx_tready,
  input  logic             cfg_to_turnoff,
  output logic             cfg_turnoff_ok,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {StIdle, StPkt0, StPkt1, StOff} state_e;

  state_e           r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_pkt_cnt0;
  logic [CNT_W-1:0] r_pkt_cnt1;
  logic             r_turnoff_ok;

  logic w_end0;
  logic w_end1;

  assign w_end0 = rq0_tvalid & s_axis_tx_tready & rq0_tlast;
  assign w_end1 = rq1_tvalid & s_axis_tx_tready & rq1_tlast;

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_pkt_cnt0   <= '0;
      r_pkt_cnt1   <= '0;
      r_turnoff_ok <= 1'b0;
    end else begin
      // Acknowledge only after a full cycle in OFF; drops on the edge that leaves OFF.
      r_turnoff_ok <= (r_state == StOff) && cfg_to_turnoff;
      case (r_state)
        StIdle: begin
          if (cfg_to_turnoff) begin
            r_state <= StOff;
          end else if (rq0_tvalid && !rq1_tvalid) begin
            r_state <= StPkt0;
          end else if (!rq0_tvalid && rq1_tvalid) begin
            r_state <= StPkt1;
          end else if (rq0_tvalid && rq1_tvalid) begin
            r_state <= r_last_grant ? StPkt0 : StPkt1;
          end
        end
        StPkt0: begin
          if (w_end0) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b0;
            r_pkt_cnt0   <= r_pkt_cnt0 + CNT_W'(1);
          end
        end
        StPkt1: begin
          if (w_end1) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_pkt_cnt1   <= r_pkt_cnt1 + CNT_W'(1);
          end
        end
        StOff: begin
          if (!cfg_to_turnoff) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Zero-latency mux of the granted source; everything idles to zero outside a packet.
  always_comb begin
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    rq0_tready       = 1'b0;
    rq1_tready       = 1'b0;
    case (r_state)
      StPkt0: begin
        s_axis_tx_tdata  = rq0_tdata;
        s_axis_tx_tkeep  = rq0_tkeep;
        s_axis_tx_tlast  = rq0_tlast;
        s_axis_tx_tvalid = rq0_tvalid;
        rq0_tready       = s_axis_tx_tready;
      end
      StPkt1: begin
        s_axis_tx_tdata  = rq1_tdata;
        s_axis_tx_tkeep  = rq1_tkeep;
        s_axis_tx_tlast  = rq1_tlast;
        s_axis_tx_tvalid = rq1_tvalid;
        rq1_tready       = s_axis_tx_tready;
      end
      default: ;
    endcase
  end

  assign cfg_turnoff_ok = r_turnoff_ok;
  assign pkt_cnt0       = r_pkt_cnt0;
  assign pkt_cnt1       = r_pkt_cnt1;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Scoreboard bench for pcie_tx_arbiter: drivers push expected beats as they present them, a
// negedge monitor predicts grants from the arbitration rules and checks every accepted beat.
`timescale 1ns / 100ps
module tb_pcie_tx_arbiter;

  localparam int unsigned CntW = 4;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic            user_clk = 1'b0;
  logic            user_reset = 1'b1;
  logic [63:0]     rq_tdata  [2];
  logic [7:0]      rq_tkeep  [2];
  logic            rq_tlast  [2];
  logic            rq_tvalid [2];
  logic            rq_tready [2];
  logic [63:0]     s_axis_tx_tdata;
  logic [7:0]      s_axis_tx_tkeep;
  logic            s_axis_tx_tlast;
  logic            s_axis_tx_tvalid;
  logic            s_axis_tx_tready;
  logic            cfg_to_turnoff = 1'b0;
  logic            cfg_turnoff_ok;
  logic [CntW-1:0] pkt_cnt0;
  logic [CntW-1:0] pkt_cnt1;

  beat_t stim_q [2][$];
  beat_t exp_q  [2][$];
  bit    rdy_pat [$];
  bit    rdy_rand = 1'b0;
  bit    drv_acc [2];
  bit    drv_abort [2];

  int          errors = 0;
  int          checks = 0;
  bit          mon_in_pkt = 1'b0;
  int          mon_cur = 0;
  int          mon_last = 1;
  int          exp_src = -1;
  int          idle_cnt = 0;
  bit          prev_off = 1'b0;
  int          first_src = -1;
  int          grant_log [$];
  logic [CntW-1:0] exp_cnt [2];

  pcie_tx_arbiter #(.CNT_W(CntW)) dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .rq0_tdata        (rq_tdata[0]),
    .rq0_tkeep        (rq_tkeep[0]),
    .rq0_tlast        (rq_tlast[0]),
    .rq0_tvalid       (rq_tvalid[0]),
    .rq0_tready       (rq_tready[0]),
    .rq1_tdata        (rq_tdata[1]),
    .rq1_tkeep        (rq_tkeep[1]),
    .rq1_tlast        (rq_tlast[1]),
    .rq1_tvalid       (rq_tvalid[1]),
    .rq1_tready       (rq_tready[1]),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .cfg_to_turnoff   (cfg_to_turnoff),
    .cfg_turnoff_ok   (cfg_turnoff_ok),
    .pkt_cnt0         (pkt_cnt0),
    .pkt_cnt1         (pkt_cnt1)
  );

  always #2 user_clk = ~user_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_tlp(input int s, input int len, input logic [63:0] base,
                          input logic [7:0] last_keep, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? {$urandom(), $urandom()} : base * 64'(i + 1);
      b.last = (i == len - 1);
      b.keep = b.last ? last_keep : 8'hFF;
      stim_q[s].push_back(b);
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while ((stim_q[0].size() != 0 || stim_q[1].size() != 0 || exp_q[0].size() != 0 ||
            exp_q[1].size() != 0 || mon_in_pkt || rq_tvalid[0] || rq_tvalid[1]) && n < bound) begin
      @(negedge user_clk);
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n < bound), 64'd1);
    @(negedge user_clk);
  endtask

  task automatic do_reset();
    @(posedge user_clk); #1;
    user_reset = 1'b1;
    repeat (2) @(negedge user_clk);
    @(posedge user_clk); #1;
    user_reset = 1'b0;
  endtask

  // Source drivers: hold each beat until accepted, record it as expected when presented.
  initial begin
    beat_t b;
    for (int s = 0; s < 2; s++) begin
      rq_tvalid[s] = 1'b0;
      rq_tdata[s]  = '0;
      rq_tkeep[s]  = '0;
      rq_tlast[s]  = 1'b0;
    end
    forever begin
      @(negedge user_clk);
      for (int s = 0; s < 2; s++) begin
        drv_acc[s]   = rq_tvalid[s] && rq_tready[s];
        drv_abort[s] = user_reset;
      end
      @(posedge user_clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (drv_abort[s] || user_reset) begin
          rq_tvalid[s] = 1'b0;
          rq_tdata[s]  = '0;
          rq_tkeep[s]  = '0;
          rq_tlast[s]  = 1'b0;
          stim_q[s].delete();
        end else if (drv_acc[s] || !rq_tvalid[s]) begin
          if (stim_q[s].size() != 0) begin
            b = stim_q[s].pop_front();
            rq_tdata[s]  = b.data;
            rq_tkeep[s]  = b.keep;
            rq_tlast[s]  = b.last;
            rq_tvalid[s] = 1'b1;
            exp_q[s].push_back(b);
          end else begin
            rq_tvalid[s] = 1'b0;
            rq_tdata[s]  = '0;
            rq_tkeep[s]  = '0;
            rq_tlast[s]  = 1'b0;
          end
        end
      end
    end
  end

  // PCIe core sink.
  initial begin
    s_axis_tx_tready = 1'b1;
    forever begin
      @(posedge user_clk); #1;
      if (rdy_pat.size() != 0) s_axis_tx_tready = rdy_pat.pop_front();
      else if (rdy_rand)       s_axis_tx_tready = ($urandom_range(0, 3) != 0);
      else                     s_axis_tx_tready = 1'b1;
    end
  end

  // Monitor and reference model.
  initial begin
    beat_t b;
    forever begin
      @(negedge user_clk);
      if (user_reset) begin
        exp_q[0].delete();
        exp_q[1].delete();
        mon_in_pkt = 1'b0;
        mon_last   = 1;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        exp_src    = -1;
        idle_cnt   = 0;
        prev_off   = 1'b0;
        first_src  = -1;
      end else begin
        chk("pkt_cnt0", 64'(pkt_cnt0), 64'(exp_cnt[0]));
        chk("pkt_cnt1", 64'(pkt_cnt1), 64'(exp_cnt[1]));
        if (!s_axis_tx_tvalid && !mon_in_pkt) begin
          chk("idle_tdata", s_axis_tx_tdata, 64'd0);
          chk("idle_ctl", 64'({s_axis_tx_tkeep, s_axis_tx_tlast, rq_tready[0], rq_tready[1]}),
              64'd0);
          // A cycle with turn-off requested, or the one right after it, cannot grant.
          if (cfg_to_turnoff || prev_off)          exp_src = -1;
          else if (rq_tvalid[0] && rq_tvalid[1])   exp_src = 1 - mon_last;
          else if (rq_tvalid[0])                   exp_src = 0;
          else if (rq_tvalid[1])                   exp_src = 1;
          else                                     exp_src = -1;
          idle_cnt = (exp_src >= 0) ? idle_cnt + 1 : 0;
          prev_off = cfg_to_turnoff;
        end
        if (s_axis_tx_tvalid) begin
          if (!mon_in_pkt) begin
            chk("grant_expected", 64'(exp_src >= 0), 64'd1);
            chk("grant_bubble", 64'(idle_cnt), 64'd1);
            mon_cur = (exp_src >= 0) ? exp_src : 0;
            if (first_src < 0) first_src = mon_cur;
            grant_log.push_back(mon_cur);
            mon_in_pkt = 1'b1;
            idle_cnt   = 0;
          end
          chk("tready_mirror", 64'({rq_tready[mon_cur], rq_tready[1 - mon_cur]}),
              64'({s_axis_tx_tready, 1'b0}));
          if (s_axis_tx_tready) begin
            if (exp_q[mon_cur].size() == 0) begin
              chk("beat_expected", 64'd0, 64'd1);
              if (s_axis_tx_tlast) mon_in_pkt = 1'b0;
            end else begin
              b = exp_q[mon_cur].pop_front();
              chk("tdata", s_axis_tx_tdata, b.data);
              chk("tkeep_tlast", 64'({s_axis_tx_tkeep, s_axis_tx_tlast}), 64'({b.keep, b.last}));
              if (b.last) begin
                mon_in_pkt       = 1'b0;
                mon_last         = mon_cur;
                exp_cnt[mon_cur] = exp_cnt[mon_cur] + CntW'(1);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge user_clk);
    chk("reset_tdata", s_axis_tx_tdata, 64'd0);
    chk("reset_ctl", 64'({s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tkeep, rq_tready[0],
                          rq_tready[1], cfg_turnoff_ok, pkt_cnt0, pkt_cnt1}), 64'd0);
    @(posedge user_clk); #1;
    user_reset = 1'b0;

    // Contention: two 2-beat TLPs per source pending together.
    @(negedge user_clk);
    grant_log.delete();
    push_tlp(0, 2, 64'hA0A0_0000_0000_0001, 8'hFF, 1'b0);
    push_tlp(0, 2, 64'hA1A1_0000_0000_0001, 8'hFF, 1'b0);
    push_tlp(1, 2, 64'hB0B0_0000_0000_0001, 8'hFF, 1'b0);
    push_tlp(1, 2, 64'hB1B1_0000_0000_0001, 8'hFF, 1'b0);
    wait_drain("contention", 60);
    chk("contention_order", 64'({grant_log.size() == 4 ? 4'd4 : 4'd0}), 64'd4);
    if (grant_log.size() == 4)
      chk("contention_seq", 64'({grant_log[0][0], grant_log[1][0], grant_log[2][0],
                                  grant_log[3][0]}), 64'b0101);
    chk("contention_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({4'd2, 4'd2}));

    // Single source rq0, 3 beats.
    @(negedge user_clk);
    push_tlp(0, 3, 64'h1111_1111_1111_1111, 8'h0F, 1'b0);
    wait_drain("single", 30);
    chk("single_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({4'd3, 4'd2}));

    // Backpressure on a 3-beat rq1 TLP.
    @(negedge user_clk);
    push_tlp(1, 3, 64'h0C0C_0000_0000_0007, 8'h3F, 1'b0);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    wait_drain("backpressure", 30);
    chk("backpressure_cnt1", 64'(pkt_cnt1), 64'd3);

    // Turn-off from IDLE: ok two edges later, drops when leaving OFF.
    @(posedge user_clk); #1;
    cfg_to_turnoff = 1'b1;
    repeat (2) @(negedge user_clk);
    chk("turnoff_ok_edge1", 64'(cfg_turnoff_ok), 64'd0);
    @(negedge user_clk);
    chk("turnoff_ok_edge2", 64'(cfg_turnoff_ok), 64'd1);
    @(posedge user_clk); #1;
    cfg_to_turnoff = 1'b0;
    repeat (2) @(negedge user_clk);
    chk("turnoff_ok_idle_fall", 64'(cfg_turnoff_ok), 64'd0);

    // Turn-off raised on beat 2 of a 4-beat rq0 TLP while rq1 waits.
    @(negedge user_clk);
    push_tlp(0, 4, 64'h0D0D_0000_0000_0003, 8'hFF, 1'b0);
    @(negedge user_clk);
    push_tlp(1, 2, 64'h0E0E_0000_0000_0005, 8'h01, 1'b0);
    repeat (2) @(posedge user_clk);
    #1;
    cfg_to_turnoff = 1'b1;
    n = 0;
    while (!cfg_turnoff_ok && n < 30) begin
      @(negedge user_clk);
      n++;
    end
    chk("midpkt_ok_rise", 64'(cfg_turnoff_ok), 64'd1);
    repeat (3) @(negedge user_clk);
    chk("midpkt_off_hold", 64'({s_axis_tx_tvalid, rq_tready[1], rq_tvalid[1]}), 64'b001);
    chk("midpkt_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({4'd4, 4'd3}));
    @(posedge user_clk); #1;
    cfg_to_turnoff = 1'b0;
    repeat (2) @(negedge user_clk);
    chk("midpkt_ok_fall", 64'(cfg_turnoff_ok), 64'd0);
    wait_drain("midpkt", 30);
    chk("midpkt_cnt_after", 64'({pkt_cnt0, pkt_cnt1}), 64'({4'd4, 4'd4}));

    // Counter wrap: 17 single-beat TLPs on rq1 from a fresh reset.
    do_reset();
    @(negedge user_clk);
    for (int i = 0; i < 17; i++) push_tlp(1, 1, 64'h0000_0000_0000_0100 + 64'(i), 8'hFF, 1'b0);
    wait_drain("wrap", 120);
    chk("wrap_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({4'd0, 4'd1}));

    // Reset on beat 2 of a 4-beat rq1 TLP, then a tie goes to port 0.
    @(negedge user_clk);
    push_tlp(1, 4, 64'h0F0F_0000_0000_0009, 8'hFF, 1'b0);
    repeat (3) @(posedge user_clk);
    #1;
    user_reset = 1'b1;
    #0.5;
    chk("midreset_tdata", s_axis_tx_tdata, 64'd0);
    chk("midreset_ctl", 64'({s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tkeep, rq_tready[0],
                             rq_tready[1], cfg_turnoff_ok, pkt_cnt0, pkt_cnt1}), 64'd0);
    repeat (2) @(negedge user_clk);
    @(posedge user_clk); #1;
    user_reset = 1'b0;
    @(negedge user_clk);
    push_tlp(0, 1, 64'h0000_0000_0000_0AAA, 8'hFF, 1'b0);
    push_tlp(1, 1, 64'h0000_0000_0000_0BBB, 8'hFF, 1'b0);
    wait_drain("tie_after_reset", 30);
    chk("tie_after_reset_src", 64'(first_src), 64'd0);
    chk("tie_after_reset_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({4'd1, 4'd1}));

    // Random traffic with random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge user_clk);
      push_tlp($urandom_range(0, 1), $urandom_range(1, 4), 64'd0, 8'($urandom_range(1, 255)),
               1'b1);
      repeat ($urandom_range(0, 4)) @(negedge user_clk);
    end
    wait_drain("random", 2000);
    rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
